// File: rtl/core_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | core_pkg                                                              |
// | Shared types and constants for the GPR writeback path.               |
// |   gpr_addr_t / gpr_data_t : GPR index and data word                   |
// |   NUM_GPR                 : number of architectural registers         |
// |   wb_req_t                : one writeback request {addr, data}        |
// | Revision: 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
package core_pkg;

  localparam int NUM_GPR = 16;

  typedef logic [3:0]  gpr_addr_t;
  typedef logic [31:0] gpr_data_t;

  typedef struct packed {
    gpr_addr_t addr;
    gpr_data_t data;
  } wb_req_t;

endpackage : core_pkg
`default_nettype wire

// File: rtl/core_wb_arb_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | core_wb_arb_if                                                        |
// | Writeback request bus (NREQ producers) plus the registered GPR write  |
// | port driven by the arbiter.                                           |
// |   req_valid/req_addr/req_data : producer requests                     |
// |   req_ready                   : one-hot grant back to producers       |
// |   wb/wb_addr/wb_data          : GPR write port                        |
// |   master : producer / GPR side       slave : arbiter side             |
// | Revision: 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
interface core_wb_arb_if #(
  parameter int NREQ = 3
);
  import core_pkg::*;

  logic      [NREQ-1:0] req_valid;
  gpr_addr_t [NREQ-1:0] req_addr;
  gpr_data_t [NREQ-1:0] req_data;
  logic      [NREQ-1:0] req_ready;
  logic                 wb;
  gpr_addr_t            wb_addr;
  gpr_data_t            wb_data;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, wb, wb_addr, wb_data
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, wb, wb_addr, wb_data
  );

endinterface : core_wb_arb_if
`default_nettype wire

// File: rtl/core_rr_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | core_rr_arb                                                           |
// | Combinational round-robin arbiter with a registered start pointer.    |
// |   clk, rst_n : clock, async active-low reset                          |
// |   req        : request vector                                        |
// |   accept     : strobe, the current grant is transferred this edge     |
// |   gnt        : one-hot grant (zero when no request)                   |
// | Revision: 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
module core_rr_arb #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         accept,
  output logic [N-1:0] gnt
);

  localparam int c_PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [c_PTR_W-1:0] r_ptr;
  logic [c_PTR_W-1:0] w_ptr_nxt;

  function automatic logic [c_PTR_W-1:0] wrap_idx(input int v);
    return c_PTR_W'(v % N);
  endfunction

  // Scan from the farthest offset down to the pointer itself, so the
  // last hit (closest to ptr) is the one that survives.
  always_comb begin
    gnt       = '0;
    w_ptr_nxt = r_ptr;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[wrap_idx(int'(r_ptr) + k)]) begin
        gnt                            = '0;
        gnt[wrap_idx(int'(r_ptr) + k)] = 1'b1;
        w_ptr_nxt                      = wrap_idx(int'(r_ptr) + k + 1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (accept) begin
      r_ptr <= w_ptr_nxt;
    end
  end

endmodule : core_rr_arb
`default_nettype wire

// File: rtl/core_wb_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | core_wb_arb                                                           |
// | Shares the single GPR write port among NREQ producers (round-robin)   |
// | and keeps a per-register count of in-flight writes for hazard checks. |
// |   clk, rst_n  : clock, async active-low reset                         |
// |   bus         : request bus in, registered GPR write port out         |
// |   issue_valid : instruction targeting issue_addr issued this cycle    |
// |   issue_addr  : its destination register                              |
// |   busy        : per-register "write pending" flags                    |
// |   sb_err      : sticky scoreboard overflow/underflow flag             |
// | Revision: 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
module core_wb_arb
  import core_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int CNTW = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  core_wb_arb_if.slave        bus,
  input  logic                issue_valid,
  input  gpr_addr_t           issue_addr,
  output logic [NUM_GPR-1:0]  busy,
  output logic                sb_err
);

  localparam logic [CNTW-1:0] c_CNT_MAX = '1;

  logic [NREQ-1:0]    w_gnt;
  logic               w_accept;
  wb_req_t            w_sel;
  logic               r_wb;
  gpr_addr_t          r_wb_addr;
  gpr_data_t          r_wb_data;
  logic [NUM_GPR-1:0] w_err;
  logic               r_sb_err;

  core_rr_arb #(.N(NREQ)) u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (bus.req_valid),
    .accept (w_accept),
    .gnt    (w_gnt)
  );

  // No downstream backpressure: any grant is a transfer.
  assign bus.req_ready = w_gnt;
  assign w_accept      = |(w_gnt & bus.req_valid);

  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) begin
        w_sel.addr = bus.req_addr[i];
        w_sel.data = bus.req_data[i];
      end
    end
  end

  // Address/data hold their last value when idle; only wb pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb      <= 1'b0;
      r_wb_addr <= '0;
      r_wb_data <= '0;
    end else begin
      r_wb <= w_accept;
      if (w_accept) begin
        r_wb_addr <= w_sel.addr;
        r_wb_data <= w_sel.data;
      end
    end
  end

  assign bus.wb      = r_wb;
  assign bus.wb_addr = r_wb_addr;
  assign bus.wb_data = r_wb_data;

  // The decrement is keyed on the registered write port, so busy drops
  // at the same edge the GPR file captures the data.
  for (genvar r = 0; r < NUM_GPR; r++) begin : g_cnt
    logic            w_inc;
    logic            w_dec;
    logic [CNTW-1:0] r_cnt;

    assign w_inc = issue_valid && (issue_addr == gpr_addr_t'(r));
    assign w_dec = r_wb && (r_wb_addr == gpr_addr_t'(r));

    assign w_err[r] = (w_inc && !w_dec && (r_cnt == c_CNT_MAX)) ||
                      (w_dec && !w_inc && (r_cnt == '0));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt <= '0;
      end else if (w_inc && !w_dec && (r_cnt != c_CNT_MAX)) begin
        r_cnt <= r_cnt + CNTW'(1);
      end else if (w_dec && !w_inc && (r_cnt != '0)) begin
        r_cnt <= r_cnt - CNTW'(1);
      end
    end

    assign busy[r] = |r_cnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sb_err <= 1'b0;
    end else if (|w_err) begin
      r_sb_err <= 1'b1;
    end
  end

  assign sb_err = r_sb_err;

endmodule : core_wb_arb
`default_nettype wire
